issue_queue: RTL

- Instruction buffer and dispatch scheduler between the IF stage and the issue/decode stage.
- Stores fetched instructions with their prediction info in a circular FIFO.
- Releases at most one instruction per cycle to issue, only when the ROB and the target unit (RS for ALU/branch ops, LSB for loads/stores) can take it.
- Drains completely on ROB-initiated flush (mispredict).

---
 rtl/issue_queue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order instruction buffer between IF and issue, one dispatch per cycle.
// Optional same-cycle empty-queue bypass enabled by defining IQ_BYPASS_EN.
`ifndef INS_DAT_W
`define INS_DAT_W 32
`endif
`ifndef REG_DAT_W
`define REG_DAT_W 32
`endif

module issue_queue #(
   parameter int DEPTH_W     = 4,
   parameter int FULL_MARGIN = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  iIF_En,
   input  logic [`INS_DAT_W-1:0] iIF_Ins,
   input  logic                  iIF_Bj,
   input  logic [`REG_DAT_W-1:0] iIF_Pc,
   input  logic [`REG_DAT_W-1:0] iIF_Pjt,
   output logic                  oIF_Full,
   input  logic                  iROB_Full,
   input  logic                  iRS_Full,
   input  logic                  iLSB_Full,
   input  logic                  iROB_Clr,
   output logic                  oIS_En,
   output logic [`INS_DAT_W-1:0] oIS_Ins,
   output logic                  oIS_Bj,
   output logic [`REG_DAT_W-1:0] oIS_Pc,
   output logic [`REG_DAT_W-1:0] oIS_Pjt
);

   localparam int DEPTH = 1 << DEPTH_W;
   localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W+1)'(DEPTH);
   localparam logic [DEPTH_W:0] FULL_THR  = (DEPTH_W+1)'(DEPTH - FULL_MARGIN);

   logic [`INS_DAT_W-1:0] ins_mem_q [DEPTH];
   logic                  bj_mem_q  [DEPTH];
   logic [`REG_DAT_W-1:0] pc_mem_q  [DEPTH];
   logic [`REG_DAT_W-1:0] pjt_mem_q [DEPTH];

   logic [DEPTH_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [DEPTH_W:0]      count_q, count_d;
   logic                  is_en_q, is_en_d;
   logic [`INS_DAT_W-1:0] is_ins_q, is_ins_d;
   logic                  is_bj_q, is_bj_d;
   logic [`REG_DAT_W-1:0] is_pc_q, is_pc_d;
   logic [`REG_DAT_W-1:0] is_pjt_q, is_pjt_d;

   logic                  accept, push_ok, push_store, pop, bypass;
   logic [`INS_DAT_W-1:0] head_ins;

   // Loads and stores go to the LSB; everything else goes to the RS.
   function automatic logic unit_ready(input logic [6:0] opcode, input logic lsb_full,
                                       input logic rs_full);
      logic is_mem;
      is_mem = (opcode == 7'b0000011) || (opcode == 7'b0100011);
      return is_mem ? !lsb_full : !rs_full;
   endfunction

   always_comb begin
      head_ins = ins_mem_q[head_q];
      accept   = en && !iROB_Clr;
      push_ok  = iIF_En && accept && (count_q != DEPTH_CNT);
      pop      = (count_q != '0) && accept && !iROB_Full
                 && unit_ready(head_ins[6:0], iLSB_Full, iRS_Full);
`ifdef IQ_BYPASS_EN
      bypass   = push_ok && (count_q == '0) && !iROB_Full
                 && unit_ready(iIF_Ins[6:0], iLSB_Full, iRS_Full);
`else
      bypass   = 1'b0;
`endif
      push_store = push_ok && !bypass;
   end

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      is_en_d  = 1'b0;
      is_ins_d = is_ins_q;
      is_bj_d  = is_bj_q;
      is_pc_d  = is_pc_q;
      is_pjt_d = is_pjt_q;
      if (en) begin
         if (iROB_Clr) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (push_store)
               tail_d = tail_q + DEPTH_W'(1);
            if (pop) begin
               head_d   = head_q + DEPTH_W'(1);
               is_en_d  = 1'b1;
               is_ins_d = head_ins;
               is_bj_d  = bj_mem_q[head_q];
               is_pc_d  = pc_mem_q[head_q];
               is_pjt_d = pjt_mem_q[head_q];
            end
            if (bypass) begin
               is_en_d  = 1'b1;
               is_ins_d = iIF_Ins;
               is_bj_d  = iIF_Bj;
               is_pc_d  = iIF_Pc;
               is_pjt_d = iIF_Pjt;
            end
            count_d = count_q + (DEPTH_W+1)'(push_store) - (DEPTH_W+1)'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         is_en_q  <= 1'b0;
         is_ins_q <= '0;
         is_bj_q  <= 1'b0;
         is_pc_q  <= '0;
         is_pjt_q <= '0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         is_en_q  <= is_en_d;
         is_ins_q <= is_ins_d;
         is_bj_q  <= is_bj_d;
         is_pc_q  <= is_pc_d;
         is_pjt_q <= is_pjt_d;
      end
   end

   // Entry storage needs no reset; occupancy is tracked solely by count.
   always_ff @(posedge clk) begin
      if (!rst && push_store) begin
         ins_mem_q[tail_q] <= iIF_Ins;
         bj_mem_q[tail_q]  <= iIF_Bj;
         pc_mem_q[tail_q]  <= iIF_Pc;
         pjt_mem_q[tail_q] <= iIF_Pjt;
      end
   end

   assign oIF_Full = (count_q >= FULL_THR);
   assign oIS_En   = is_en_q;
   assign oIS_Ins  = is_ins_q;
   assign oIS_Bj   = is_bj_q;
   assign oIS_Pc   = is_pc_q;
   assign oIS_Pjt  = is_pjt_q;

endmodule
